// File: rtl/correction_result_tx.sv
// Output framer: latches decode results on start and streams them as bytes over a valid/ready link.
// Optional trailing XOR checksum byte enabled by defining CORRECTION_RESULT_TX_CHECKSUM_EN.
module correction_result_tx #(
    parameter int GRID_WIDTH_X = 6,
    parameter int GRID_WIDTH_Z = 2,
    parameter int GRID_WIDTH_U = 5,
    parameter int NUM_CONTEXTS = 1,
    localparam int NS         = (GRID_WIDTH_X - 1) * GRID_WIDTH_Z,
    localparam int EW         = NS + 1,
    localparam int UD         = GRID_WIDTH_X * GRID_WIDTH_Z,
    localparam int CPR        = NS + EW + UD,
    localparam int CBPR       = (CPR + 7) >> 3,
    localparam int ROUNDS     = ((GRID_WIDTH_U + NUM_CONTEXTS - 1) / NUM_CONTEXTS) * NUM_CONTEXTS,
    localparam int CORR_BYTES = CBPR * ROUNDS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [15:0]             iteration_count,
    input  logic [31:0]             cycle_count,
    input  logic [CPR*ROUNDS-1:0]   corrections,
    output logic [7:0]              output_data,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic                    busy,
    output logic                    done
);

    localparam int CNT_W = (CORR_BYTES > 1) ? $clog2(CORR_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(CORR_BYTES - 1);

`ifdef CORRECTION_RESULT_TX_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, ITER, CYC_HI, CYC_LO, CORR, CSUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, ITER, CYC_HI, CYC_LO, CORR} state_t;
`endif

    state_t                       state, state_nxt;
    logic [CNT_W-1:0]             byte_cnt;
    logic [7:0]                   iter_byte;
    logic [15:0]                  cyc_word;
    logic [CORR_BYTES-1:0][7:0]   corr_bytes;
    logic [CORR_BYTES*8-1:0]      corr_pad;
    logic                         xfer;
    logic                         frame_end;

    // Each round is widened to a whole number of bytes, pad bits forced to zero.
    for (genvar r = 0; r < ROUNDS; r++) begin : g_round
        assign corr_pad[r*CBPR*8 +: CPR] = corrections[r*CPR +: CPR];
        if (CBPR*8 > CPR) begin : g_pad
            assign corr_pad[r*CBPR*8+CPR +: CBPR*8-CPR] = '0;
        end
    end

    assign xfer         = output_valid && output_ready;
    assign output_valid = (state != IDLE);
    assign busy         = (state != IDLE);

`ifdef CORRECTION_RESULT_TX_CHECKSUM_EN
    logic [7:0] csum;
    assign frame_end = (state == CSUM) && xfer;
`else
    assign frame_end = (state == CORR) && (byte_cnt == LAST_BYTE) && xfer;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            done       <= 1'b0;
            iter_byte  <= '0;
            cyc_word   <= '0;
            corr_bytes <= '0;
        end else begin
            state <= state_nxt;
            done  <= frame_end;
            if (state == IDLE && start) begin
                iter_byte  <= (iteration_count > 16'd255) ? 8'hFF : iteration_count[7:0];
                cyc_word   <= (cycle_count > 32'd65535) ? 16'hFFFF : cycle_count[15:0];
                corr_bytes <= corr_pad;
                byte_cnt   <= '0;
            end else if (state == CORR && xfer) begin
                byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
            end
        end
    end

`ifdef CORRECTION_RESULT_TX_CHECKSUM_EN
    // Running XOR of every byte already handed downstream.
    always_ff @(posedge clk) begin
        if (reset)
            csum <= '0;
        else if (state == IDLE && start)
            csum <= '0;
        else if (xfer)
            csum <= csum ^ output_data;
    end
`endif

    always_comb begin
        state_nxt   = state;
        output_data = 8'h00;
        case (state)
            IDLE: begin
                if (start) state_nxt = ITER;
            end
            ITER: begin
                output_data = iter_byte;
                if (xfer) state_nxt = CYC_HI;
            end
            CYC_HI: begin
                output_data = cyc_word[15:8];
                if (xfer) state_nxt = CYC_LO;
            end
            CYC_LO: begin
                output_data = cyc_word[7:0];
                if (xfer) state_nxt = CORR;
            end
            CORR: begin
                output_data = corr_bytes[byte_cnt];
                if (xfer && byte_cnt == LAST_BYTE) begin
`ifdef CORRECTION_RESULT_TX_CHECKSUM_EN
                    state_nxt = CSUM;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef CORRECTION_RESULT_TX_CHECKSUM_EN
            CSUM: begin
                output_data = csum;
                if (xfer) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

endmodule
